// File: rtl/button_repeat.sv
// Turns a clean debounced button level into press / auto-repeat / release events for the UI.
// Optional macro BTN_REPEAT_ACCEL_EN halves the repeat interval after ACCEL_COUNT repeats in one hold.
module button_repeat #(
    parameter int DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int ACCEL_COUNT   = 8,
    parameter int CW            = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    output logic press_tick,
    output logic repeat_tick,
    output logic release_tick,
    output logic step_tick,
    output logic held,
    output logic long_hold
);

    localparam bit PARAMS_OK = (DELAY_CYCLES >= 2) && (REPEAT_CYCLES >= 2) && (ACCEL_COUNT >= 1) &&
                               (longint'(DELAY_CYCLES) < (64'd1 << CW)) &&
                               (longint'(REPEAT_CYCLES) < (64'd1 << CW));

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("button_repeat: illegal parameter combination");
        end
    endgenerate

    localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        LOCK,
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [CW-1:0]   interval_last;
    logic            press_nx, repeat_nx, release_nx;
    logic            held_nx, long_nx, step_nx;

`ifdef BTN_REPEAT_ACCEL_EN
    localparam int              RW        = $clog2(ACCEL_COUNT + 1);
    localparam logic [RW-1:0]   RCNT_SAT  = RW'(ACCEL_COUNT);
    localparam logic [CW-1:0]   FAST_LAST = CW'(REPEAT_CYCLES / 2 - 1);

    logic [RW-1:0] rcnt, rcnt_nx;

    assign interval_last = (rcnt == RCNT_SAT) ? FAST_LAST : REPEAT_LAST;

    // rcnt counts repeats within one hold and saturates; any press or release restarts it
    always_comb begin
        rcnt_nx = rcnt;
        if (press_nx || release_nx) begin
            rcnt_nx = '0;
        end else if (repeat_nx && (rcnt != RCNT_SAT)) begin
            rcnt_nx = rcnt + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_nx;
        end
    end
`else
    assign interval_last = REPEAT_LAST;
`endif

    // Release is tested before the terminal count, so a release always beats a repeat
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        press_nx   = 1'b0;
        repeat_nx  = 1'b0;
        release_nx = 1'b0;
        case (state)
            LOCK: begin
                if (!db_level) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                if (db_level) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    press_nx = 1'b1;
                end
            end
            HOLD: begin
                if (!db_level) begin
                    state_nx   = IDLE;
                    release_nx = 1'b1;
                end else if (cnt == DELAY_LAST) begin
                    state_nx  = REPEAT;
                    cnt_nx    = '0;
                    repeat_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            REPEAT: begin
                if (!db_level) begin
                    state_nx   = IDLE;
                    release_nx = 1'b1;
                end else if (cnt == interval_last) begin
                    cnt_nx    = '0;
                    repeat_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = LOCK;
            end
        endcase
        step_nx = press_nx | repeat_nx;
        held_nx = (state_nx == HOLD) || (state_nx == REPEAT);
        long_nx = (state_nx == REPEAT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOCK;
            cnt          <= '0;
            press_tick   <= 1'b0;
            repeat_tick  <= 1'b0;
            release_tick <= 1'b0;
            step_tick    <= 1'b0;
            held         <= 1'b0;
            long_hold    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            press_tick   <= press_nx;
            repeat_tick  <= repeat_nx;
            release_tick <= release_nx;
            step_tick    <= step_nx;
            held         <= held_nx;
            long_hold    <= long_nx;
        end
    end

endmodule
